apb_requester: RTL and testbench
================================

# apb_requester

APB requester (initiator) that turns single commands from a valid/ready command port into APB3 transfers and returns each result on a valid/ready response port. It sits between a processor-side bus adapter or test sequencer and the APB slave peripherals (7-segment display, GPIO, timers); address decode to individual pSEL lines happens downstream. It runs one transfer at a time, and a wait-state timeout converts a hung slave into an error response.

## Interface
- DW, 32, data width
- AW, 32, address width
- TIMEOUT, 16, maximum ACCESS cycles with pREADY low before abort; 0 disables the timeout
- pCLK  in  1  clock; everything is sampled on the rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AW  transfer address
- cmd_wdata  in  DW  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DW  read data; 0 for writes and for timeouts
- rsp_slverr  out  1  slave reported an error, or the transfer timed out
- rsp_timeout  out  1  transfer was aborted by the timeout
- pADDR  out  AW  APB address
- pSEL  out  1  APB select
- pENABLE  out  1  APB enable
- pWRITE  out  1  APB direction
- pWDATA  out  DW  APB write data
- pRDATA  in  DW  APB read data
- pREADY  in  1  APB ready
- pSLVERR  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid is high, latch cmd_write, cmd_addr and cmd_wdata into pWRITE, pADDR and pWDATA, then go to SETUP.
- SETUP:
  - pSEL=1, pENABLE=0.
  - Go to ACCESS unconditionally after one cycle.
- ACCESS:
  - pSEL=1, pENABLE=1.
  - When pREADY=1, capture pSLVERR into rsp_slverr. Capture pRDATA into rsp_rdata if the transfer is a read; otherwise rsp_rdata=0. Clear rsp_timeout, then go to RESP.
  - When pREADY=0, increment the wait counter. The counter width is enough to hold TIMEOUT.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT, abort: rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - If pREADY=1 in the same cycle the counter would reach TIMEOUT, pREADY wins and the transfer completes normally.
- RESP:
  - rsp_valid=1, with rsp_rdata, rsp_slverr and rsp_timeout held stable.
  - When rsp_ready=1, go to IDLE.
- The wait counter clears on entry to SETUP.
- cmd_ready=0 in every state except IDLE. Commands presented in other states are not accepted and stay pending at the source.
- pSEL and pENABLE are decoded from the state register only; they do not depend combinationally on any input.
- rsp_valid=1 only in RESP.
- pADDR, pWRITE and pWDATA change only when a command is accepted. They hold their values through IDLE afterwards.
- Reset values: state=IDLE, pSEL=0, pENABLE=0, pADDR=0, pWRITE=0, pWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, counter=0. cmd_ready=1 while reset is deasserted in IDLE.
- Reset asserted mid-transfer (SETUP, ACCESS or RESP):
  - pSEL, pENABLE and rsp_valid drop asynchronously.
  - The transfer and any pending response are discarded; no response is produced.

## Timing
- Command accepted at edge 0, then:
  - Cycle 1: SETUP.
  - Cycle 2: first ACCESS cycle.
- A slave with zero wait states (pREADY=1 in cycle 2) gives rsp_valid=1 in cycle 3.
- With rsp_ready=1 in cycle 3, cmd_ready=1 again in cycle 4. Minimum occupancy is 4 cycles per transfer.
- Each pREADY=0 cycle in ACCESS adds one cycle of latency.
- For a timeout, rsp_valid rises in the cycle after the TIMEOUT-th consecutive pREADY=0 ACCESS cycle.
- pSEL and pENABLE deassert in the cycle after pREADY is sampled high, so there is exactly one ACCESS cycle with pREADY=1 per transfer.
- rsp_ready low in RESP stalls the block indefinitely. APB stays idle (pSEL=0) during the stall.

## Test plan
- **Write, zero wait:**
  - Stimulus: cmd write, addr 0x04, data 0x12345678; slave holds pREADY=1.
  - Required: pSEL=1/pENABLE=0 in cycle 1; pSEL=1/pENABLE=1 in cycle 2; pADDR=0x04, pWDATA=0x12345678 and pWRITE=1 stable through both cycles.
  - Required: rsp_valid in cycle 3 with rsp_rdata=0, rsp_slverr=0.
- **Read, 3 wait states:**
  - Stimulus: cmd read, addr 0x00; pREADY low for 3 ACCESS cycles, then high with pRDATA=0x1.
  - Required: rsp_valid in cycle 6 with rsp_rdata=0x1; pSEL/pENABLE held high for 4 ACCESS cycles.
- **Slave error:**
  - Stimulus: read to 0x7C; pREADY=1 with pSLVERR=1 in the first ACCESS cycle.
  - Required: rsp_slverr=1, rsp_timeout=0.
- **Timeout (TIMEOUT=4):**
  - Stimulus: pREADY held at 0.
  - Required: exactly 4 ACCESS cycles, then rsp_valid with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0; pSEL=0 afterwards.
  - Boundary: pREADY=1 on the 4th ACCESS cycle must complete normally with rsp_timeout=0.
- **Backpressure and back-to-back:**
  - Stimulus: hold rsp_ready=0 for 5 cycles while cmd_valid stays high with a second command.
  - Required: cmd_ready=0 and the response fields stable throughout.
  - Required: after rsp_ready, the second command is accepted the next cycle and drives its own address.
- **Reset mid-ACCESS:**
  - Stimulus: assert reset between edges during ACCESS.
  - Required: pSEL, pENABLE and rsp_valid go low immediately.
  - Required: after release, cmd_ready=1 and no response is emitted for the aborted command.

Source files
------------

// File: rtl/apb_requester.sv
// APB3 requester: accepts one command at a time on a valid/ready port,
// runs the SETUP/ACCESS handshake on APB and returns the result on a
// valid/ready response port. A wait-state timeout turns a hung slave
// into an error response.
module apb_requester #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          pCLK,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_slverr,
   output logic          rsp_timeout,
   output logic [AW-1:0] pADDR,
   output logic          pSEL,
   output logic          pENABLE,
   output logic          pWRITE,
   output logic [DW-1:0] pWDATA,
   input  logic [DW-1:0] pRDATA,
   input  logic          pREADY,
   input  logic          pSLVERR
);

   // Wait counter must be able to hold TIMEOUT; one bit minimum when disabled.
   localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int CW1 = CW + 1;
   localparam logic [CW:0] TO_LIM = CW1'(TIMEOUT);
   localparam bit          TO_EN  = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic          done_s;
   logic          abort_s;
   logic [CW-1:0] cnt_r;
   logic [CW:0]   cnt_inc_s;

   assign cnt_inc_s = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};

   // State register.
   always_ff @(posedge pCLK or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; pREADY takes priority over the timeout in the same cycle.
   always_comb begin
      state_s = state_r;
      done_s  = 1'b0;
      abort_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_s = ST_SETUP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_s = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pREADY) begin
               done_s  = 1'b1;
               state_s = ST_RESP;
            end else if (TO_EN && (cnt_inc_s == TO_LIM)) begin
               abort_s = 1'b1;
               state_s = ST_RESP;
            end else begin
               state_s = ST_ACCESS;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs registered from the next state so they never follow inputs combinationally.
   always_ff @(posedge pCLK or posedge reset) begin
      if (reset) begin
         pSEL      <= 1'b0;
         pENABLE   <= 1'b0;
         rsp_valid <= 1'b0;
         cmd_ready <= 1'b1;
      end else begin
         pSEL      <= (state_s == ST_SETUP) || (state_s == ST_ACCESS);
         pENABLE   <= (state_s == ST_ACCESS);
         rsp_valid <= (state_s == ST_RESP);
         cmd_ready <= (state_s == ST_IDLE);
      end
   end

   // Wait-state counter: cleared on entry to SETUP, counts pREADY-low ACCESS cycles.
   always_ff @(posedge pCLK or posedge reset) begin
      if (reset) begin
         cnt_r <= {CW{1'b0}};
      end else if (state_s == ST_SETUP) begin
         cnt_r <= {CW{1'b0}};
      end else if ((state_r == ST_ACCESS) && !pREADY) begin
         cnt_r <= cnt_inc_s[CW-1:0];
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // APB address/direction/data latch only on command acceptance and hold afterwards.
   always_ff @(posedge pCLK or posedge reset) begin
      if (reset) begin
         pADDR  <= {AW{1'b0}};
         pWRITE <= 1'b0;
         pWDATA <= {DW{1'b0}};
      end else if ((state_r == ST_IDLE) && cmd_valid) begin
         pADDR  <= cmd_addr;
         pWRITE <= cmd_write;
         pWDATA <= cmd_wdata;
      end else begin
         pADDR  <= pADDR;
         pWRITE <= pWRITE;
         pWDATA <= pWDATA;
      end
   end

   // Response fields captured at completion or abort and held through RESP.
   always_ff @(posedge pCLK or posedge reset) begin
      if (reset) begin
         rsp_rdata   <= {DW{1'b0}};
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
      end else if (done_s) begin
         rsp_rdata   <= pWRITE ? {DW{1'b0}} : pRDATA;
         rsp_slverr  <= pSLVERR;
         rsp_timeout <= 1'b0;
      end else if (abort_s) begin
         rsp_rdata   <= {DW{1'b0}};
         rsp_slverr  <= 1'b1;
         rsp_timeout <= 1'b1;
      end else begin
         rsp_rdata   <= rsp_rdata;
         rsp_slverr  <= rsp_slverr;
         rsp_timeout <= rsp_timeout;
      end
   end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed test-plan commands
// followed by random commands, each predicted by a transaction-level model
// (wait count -> number of ACCESS cycles and response contents).
module tb_apb_requester;

   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int TIMEOUT = 4;
   localparam int N       = 48;

   logic          pclk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_slverr;
   logic          rsp_timeout;
   logic [AW-1:0] paddr;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;

   int checks_r = 0;
   int errors_r = 0;

   // Command table
   logic          c_wr   [N];
   logic [AW-1:0] c_addr [N];
   logic [DW-1:0] c_wd   [N];
   logic [DW-1:0] c_rd   [N];
   logic          c_err  [N];
   int            c_wait [N];
   int            c_hold [N];

   apb_requester #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .pCLK        (pclk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .pADDR       (paddr),
      .pSEL        (psel),
      .pENABLE     (penable),
      .pWRITE      (pwrite),
      .pWDATA      (pwdata),
      .pRDATA      (prdata),
      .pREADY      (pready),
      .pSLVERR     (pslverr)
   );

   // Free-running clock.
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_r++;
      if (got !== exp) begin
         errors_r++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic present_cmd(input int i);
      cmd_valid = 1'b1;
      cmd_write = c_wr[i];
      cmd_addr  = c_addr[i];
      cmd_wdata = c_wd[i];
   endtask

   task automatic check_apb_fields(input string tag, input int i);
      check_eq({tag, "_paddr"},  paddr,  c_addr[i]);
      check_eq({tag, "_pwrite"}, pwrite, c_wr[i]);
      check_eq({tag, "_pwdata"}, pwdata, c_wd[i]);
   endtask

   // One full transfer of command i, starting in a cycle where the DUT is idle.
   task automatic do_xfer(input int i);
      int            n_acc;
      bit            to;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
      to      = (TIMEOUT != 0) && (c_wait[i] >= TIMEOUT);
      n_acc   = to ? TIMEOUT : c_wait[i] + 1;
      exp_rd  = (to || c_wr[i]) ? '0 : c_rd[i];
      exp_err = to ? 1'b1 : c_err[i];

      present_cmd(i);
      check_eq("idle_cmd_ready", cmd_ready, 1'b1);
      check_eq("idle_rsp_valid", rsp_valid, 1'b0);
      check_eq("idle_psel", psel, 1'b0);
      tick();
      // SETUP cycle
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_write = 1'($urandom);
      check_eq("setup_psel", psel, 1'b1);
      check_eq("setup_penable", penable, 1'b0);
      check_eq("setup_cmd_ready", cmd_ready, 1'b0);
      check_eq("setup_rsp_valid", rsp_valid, 1'b0);
      check_apb_fields("setup", i);
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
      for (int k = 1; k <= n_acc; k++) begin
         tick();
         check_eq("access_psel", psel, 1'b1);
         check_eq("access_penable", penable, 1'b1);
         check_eq("access_cmd_ready", cmd_ready, 1'b0);
         check_eq("access_rsp_valid", rsp_valid, 1'b0);
         check_apb_fields("access", i);
         pready  = (k > c_wait[i]);
         prdata  = pready ? c_rd[i]  : $urandom;
         pslverr = pready ? c_err[i] : 1'($urandom);
      end
      tick();
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
      // RESP, possibly stalled with the next command pending
      for (int h = 0; h <= c_hold[i]; h++) begin
         check_eq("resp_valid", rsp_valid, 1'b1);
         check_eq("resp_rdata", rsp_rdata, exp_rd);
         check_eq("resp_slverr", rsp_slverr, exp_err);
         check_eq("resp_timeout", rsp_timeout, to);
         check_eq("resp_psel", psel, 1'b0);
         check_eq("resp_penable", penable, 1'b0);
         check_eq("resp_cmd_ready", cmd_ready, 1'b0);
         check_apb_fields("resp", i);
         rsp_ready = (h == c_hold[i]);
         if ((h < c_hold[i]) && (i + 1 < N)) present_cmd(i + 1);
         tick();
      end
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
   endtask

   // Main stimulus.
   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;

      // Directed entries from the test plan, then random ones.
      for (int i = 0; i < N; i++) begin
         c_wr[i]   = 1'($urandom);
         c_addr[i] = $urandom & 32'hFFFF_FFFC;
         c_wd[i]   = $urandom;
         c_rd[i]   = $urandom;
         c_err[i]  = 1'($urandom_range(0, 3) == 0);
         c_wait[i] = $urandom_range(0, 6);
         c_hold[i] = $urandom_range(0, 3);
      end
      c_wr[0] = 1'b1; c_addr[0] = 32'h04; c_wd[0] = 32'h1234_5678; c_wait[0] = 0; c_err[0] = 1'b0; c_hold[0] = 0;
      c_wr[1] = 1'b0; c_addr[1] = 32'h00; c_rd[1] = 32'h1;         c_wait[1] = 3; c_err[1] = 1'b0; c_hold[1] = 0;
      c_wr[2] = 1'b0; c_addr[2] = 32'h7C; c_wait[2] = 0; c_err[2] = 1'b1; c_hold[2] = 0;
      c_wr[3] = 1'b0; c_addr[3] = 32'h20; c_wait[3] = 10; c_hold[3] = 0;
      c_wr[4] = 1'b0; c_addr[4] = 32'h24; c_wait[4] = TIMEOUT - 1; c_err[4] = 1'b0; c_hold[4] = 0;
      c_wr[5] = 1'b1; c_addr[5] = 32'h30; c_wait[5] = 1; c_hold[5] = 5;
      c_wr[6] = 1'b1; c_addr[6] = 32'h34; c_wait[6] = 0; c_hold[6] = 0;

      repeat (3) @(posedge pclk);
      @(negedge pclk);
      reset = 1'b0;
      tick();
      check_eq("rst_cmd_ready", cmd_ready, 1'b1);
      check_eq("rst_psel", psel, 1'b0);
      check_eq("rst_penable", penable, 1'b0);
      check_eq("rst_paddr", paddr, '0);
      check_eq("rst_pwrite", pwrite, 1'b0);
      check_eq("rst_pwdata", pwdata, '0);
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_rsp_rdata", rsp_rdata, '0);
      check_eq("rst_rsp_slverr", rsp_slverr, 1'b0);
      check_eq("rst_rsp_timeout", rsp_timeout, 1'b0);

      for (int i = 0; i < N; i++) begin
         do_xfer(i);
         // Occasional idle gaps after the back-to-back pair.
         if (i > 6) begin
            repeat ($urandom_range(0, 2)) begin
               check_eq("gap_cmd_ready", cmd_ready, 1'b1);
               check_eq("gap_psel", psel, 1'b0);
               check_apb_fields("gap", i);
               tick();
            end
         end
      end

      // Reset in the middle of ACCESS.
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h10;
      tick();
      cmd_valid = 1'b0;
      pready    = 1'b0;
      tick();
      check_eq("pre_rst_psel", psel, 1'b1);
      check_eq("pre_rst_penable", penable, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_rst_psel", psel, 1'b0);
      check_eq("async_rst_penable", penable, 1'b0);
      check_eq("async_rst_rsp_valid", rsp_valid, 1'b0);
      @(negedge pclk);
      reset     = 1'b0;
      pready    = 1'b1;
      rsp_ready = 1'b1;
      tick();
      check_eq("post_rst_cmd_ready", cmd_ready, 1'b1);
      check_eq("post_rst_paddr", paddr, '0);
      repeat (6) begin
         prdata = $urandom;
         check_eq("post_rst_rsp_valid", rsp_valid, 1'b0);
         check_eq("post_rst_psel", psel, 1'b0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
      $finish;
   end

endmodule
